// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: byte stream to configuration chain serialiser.
// Optional CRC-8 of the returned chain tail: define CCFF_TAIL_CRC_EN.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 22,
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [7:0]        tail_crc
`endif
);

    localparam int RC_W = $clog2(DATA_W + 1);
    localparam int SUM_W = ((CNT_W > RC_W) ? CNT_W : RC_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RC_W-1:0]   reg_cnt;
    logic [DATA_W-1:0] shreg;
    logic [SUM_W-1:0]  committed;
    logic              take;

    // bits already shifted plus bits still buffered
    assign committed = SUM_W'(bit_cnt) + SUM_W'(reg_cnt);

    assign in_ready = (state == LOAD)
                   && (reg_cnt <= RC_W'(1))
                   && (committed < SUM_W'(CHAIN_LEN));

    assign take = in_valid && in_ready;

    // Control FSM, shift register and registered chain outputs
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            reg_cnt       <= '0;
            shreg         <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            cfg_done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    ccff_shift_en <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        cfg_done <= 1'b0;
                        bit_cnt  <= '0;
                        reg_cnt  <= '0;
                        shreg    <= '0;
                    end
                end
                LOAD: begin
                    if (bit_cnt == CNT_W'(CHAIN_LEN)) begin
                        // chain full: drop leftover bits of the last word
                        state         <= DONE;
                        busy          <= 1'b0;
                        cfg_done      <= 1'b1;
                        ccff_shift_en <= 1'b0;
                        reg_cnt       <= '0;
                        shreg         <= '0;
                    end else if (take && (reg_cnt == '0)) begin
                        // starved: the new MSB goes straight to the chain
                        ccff_head     <= in_data[DATA_W-1];
                        ccff_shift_en <= 1'b1;
                        shreg         <= in_data << 1;
                        reg_cnt       <= RC_W'(DATA_W - 1);
                        bit_cnt       <= bit_cnt + 1'b1;
                    end else if (reg_cnt != '0) begin
                        ccff_head     <= shreg[DATA_W-1];
                        ccff_shift_en <= 1'b1;
                        bit_cnt       <= bit_cnt + 1'b1;
                        if (take) begin
                            shreg   <= in_data;
                            reg_cnt <= RC_W'(DATA_W);
                        end else begin
                            shreg   <= shreg << 1;
                            reg_cnt <= reg_cnt - 1'b1;
                        end
                    end else begin
                        ccff_shift_en <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cfg_done      <= 1'b0;
                    ccff_shift_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef CCFF_TAIL_CRC_EN
    // CRC-8 (poly 0x07) over the old configuration leaving the chain tail
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            tail_crc <= 8'h00;
        end else if (start && (state != LOAD)) begin
            tail_crc <= 8'h00;
        end else if (ccff_shift_en) begin
            tail_crc <= {tail_crc[6:0], 1'b0}
                      ^ ({8{tail_crc[7] ^ ccff_tail}} & 8'h07);
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: scoreboard bench for the chain loader.
// Define CCFF_TAIL_CRC_EN to also check tail_crc.
module tb_ccff_bitstream_loader;

    localparam int CL = 22;
    localparam int DW = 8;
    localparam int NW = (CL + DW - 1) / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail = 1'b0;
    logic          busy;
    logic          cfg_done;
`ifdef CCFF_TAIL_CRC_EN
    logic [7:0]    tail_crc;
`endif

    always #5 clk = ~clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN(CL),
        .DATA_W(DW)
    ) dut (
        .prog_clk(clk),
        .prog_reset_n(rst_n),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ccff_head(ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail(ccff_tail),
        .busy(busy),
        .cfg_done(cfg_done)
`ifdef CCFF_TAIL_CRC_EN
        ,
        .tail_crc(tail_crc)
`endif
    );

    int   tests = 0;
    int   fails = 0;
    bit   expq[$];
    bit   tailq[$];
    int   mon_shift = 0;
    int   mon_bubble = 0;
    bit   mon_en = 1'b0;
    logic prev_head = 1'b0;
    bit   exp_bit;
    int   pushed = 0;
    int   tail_mode = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC-8 as polynomial long division of message * x^8 by 0x107
    function automatic logic [7:0] crc_ref(input bit q[$]);
        bit         m[$];
        logic [8:0] poly9;
        logic [7:0] r;
        poly9 = 9'h107;
        m = q;
        for (int k = 0; k < 8; k++) m.push_back(1'b0);
        for (int i = 0; i < q.size(); i++)
            if (m[i])
                for (int j = 1; j <= 8; j++)
                    m[i+j] = m[i+j] ^ poly9[8-j];
        for (int k = 0; k < 8; k++) r[7-k] = m[q.size()+k];
        return r;
    endfunction

    // tail bit changes away from the sampling edge
    always @(posedge clk) begin
        #2;
        if (tail_mode == 1) ccff_tail = 1'b1;
        else if (tail_mode == 2) ccff_tail = 1'b0;
        else ccff_tail = 1'($urandom_range(0, 1));
    end

    // monitor: every shift cycle pops one expected bit
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ccff_shift_en) begin
                mon_shift++;
                tailq.push_back(ccff_tail);
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_shift: got shift with empty queue, expected none");
                end else begin
                    exp_bit = expq.pop_front();
                    chk("head_bit", ccff_head, exp_bit);
                end
            end else if (busy) begin
                mon_bubble++;
                chk("head_hold", ccff_head, prev_head);
            end
        end
        prev_head = ccff_head;
    end

    task automatic feed(input logic [DW-1:0] w[NW], input int d[NW],
                        input bit pulse);
        for (int i = 0; i < NW; i++) begin
            int   dl;
            int   guard;
            bit   got;
            bit   pulsed;
            logic r;
            dl = d[i];
            guard = 0;
            got = 1'b0;
            pulsed = 1'b0;
            while (!got) begin
                @(negedge clk);
                r = in_ready;
                start = 1'b0;
                if (r && dl > 0) begin
                    in_valid = 1'b0;
                    dl--;
                    if (pulse && !pulsed) begin
                        start = 1'b1;
                        pulsed = 1'b1;
                    end
                end else begin
                    in_valid = 1'b1;
                    in_data = w[i];
                end
                @(posedge clk);
                if (r && in_valid) begin
                    got = 1'b1;
                    for (int b = DW - 1; b >= 0; b--)
                        if (pushed < CL) begin
                            expq.push_back(w[i][b]);
                            pushed++;
                        end
                end
                guard++;
                if (!got && guard > 100) begin
                    tests++;
                    fails++;
                    $display("FAIL accept_timeout: got no accept for word %0d, expected accept", i);
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
        chk("ready_after_last", in_ready, 0);
    endtask

    task automatic begin_load();
        @(negedge clk);
        start = 1'b1;
        pushed = 0;
        mon_shift = 0;
        mon_bubble = 0;
        expq.delete();
        tailq.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", cfg_done, 0);
    endtask

    task automatic run_load(input logic [DW-1:0] w[NW], input int d[NW],
                            input bit pulse);
        int g;
        int exp_b;
        begin_load();
        feed(w, d, pulse);
        exp_b = 1 + d[0];
        for (int i = 1; i < NW; i++)
            if (d[i] > 1) exp_b += d[i] - 1;
        g = 0;
        while (!cfg_done && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("cfg_done", cfg_done, 1);
        chk("shift_count", mon_shift, CL);
        chk("bubble_count", mon_bubble, exp_b);
        chk("queue_left", expq.size(), 0);
        chk("busy_in_done", busy, 0);
        chk("ready_in_done", in_ready, 0);
`ifdef CCFF_TAIL_CRC_EN
        chk("tail_crc", tail_crc, crc_ref(tailq));
        repeat (3) @(negedge clk);
        chk("tail_crc_hold", tail_crc, crc_ref(tailq));
`endif
    endtask

    initial begin
        logic [DW-1:0] w[NW];
        int            d[NW];
        int            rdy;
        int            g;

        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_shift", ccff_shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", cfg_done, 0);
`ifdef CCFF_TAIL_CRC_EN
        chk("rst_crc", tail_crc, 8'h00);
`endif
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        rdy = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) rdy++;
        end
        in_valid = 1'b0;
        chk("idle_ready_cycles", rdy, 0);
        chk("idle_busy", busy, 0);

        tail_mode = 1;
        w = '{8'hA5, 8'h3C, 8'hFF};
        d = '{0, 0, 0};
        run_load(w, d, 1'b0);

        tail_mode = 2;
        d = '{0, 6, 6};
        run_load(w, d, 1'b0);
`ifdef CCFF_TAIL_CRC_EN
        chk("crc_zero_tail", tail_crc, 8'h00);
`endif

        tail_mode = 0;
        for (int i = 0; i < NW; i++) w[i] = DW'($urandom);
        d = '{0, 2, 1};
        run_load(w, d, 1'b1);

        for (int i = 0; i < NW; i++) w[i] = DW'($urandom);
        d = '{0, 0, 0};
        begin_load();
        fork
            feed(w, d, 1'b0);
        join_none
        g = 0;
        while (mon_shift < 10 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("abort_reached", (mon_shift >= 10) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("abort_ready", in_ready, 0);
        chk("abort_head", ccff_head, 0);
        chk("abort_shift", ccff_shift_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", cfg_done, 0);
        disable fork;
        in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_shift_held", ccff_shift_en, 0);
        rst_n = 1'b1;
        expq.delete();
        for (int i = 0; i < NW; i++) w[i] = DW'($urandom);
        run_load(w, d, 1'b0);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NW; i++) begin
                w[i] = DW'($urandom);
                d[i] = $urandom_range(0, 3);
            end
            run_load(w, d, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
